// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the 8-bit RISC fetch sequencer: default widths,
// reset vector and the fetch FSM state encoding.
package fetch_sequencer_pkg;

    localparam int             FS_ADDR_W    = 8;
    localparam int             FS_INSTR_W   = 16;
    localparam logic [7:0]     FS_RESET_VEC = 8'h00;

    // Fetch FSM states; the encoding is fixed so that waveforms and
    // debug tooling across the core agree on the values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction fetch sequencer. Issues one request
// to instruction memory at a time, buffers the returned word for decode,
// and applies branch/jump redirects and a sticky halt.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W    = FS_ADDR_W,
    parameter int                INSTR_W   = FS_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(FS_RESET_VEC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc
);

    fetch_state_t      state;
    logic              halt_pend;
    logic [ADDR_W-1:0] pc_inc;

    // The request address is the PC itself; the PC only moves on an ack or
    // a redirect, so the address is stable for the whole handshake.
    assign imem_addr = pc;

    // Sequential increment wraps modulo 2^ADDR_W with no carry out.
    assign pc_inc = pc + ADDR_W'(1);

    // Fetch FSM with registered outputs, PC register and halt latch.
    // NOTE: reset is synchronous (sampled only on the clock edge), and all
    // state uses non-blocking assignments so every register sees the values
    // from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_VEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            halted      <= 1'b0;
            halt_pend   <= 1'b0;
        end else begin
            // A halt request is remembered until the pipeline drains.
            if (halt) begin
                halt_pend <= 1'b1;
            end

            if (state != HALT && redirect) begin
                // Redirect wins over any same-cycle ack or ready: returned
                // data is dropped, the held instruction is flushed, and the
                // next fetch starts at the target.
                pc          <= redirect_pc;
                instr_valid <= 1'b0;
                imem_req    <= 1'b1;
                state       <= REQ;
            end else begin
                case (state)
                    IDLE: begin
                        if (halt_pend) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            imem_req <= 1'b1;
                            state    <= REQ;
                        end
                    end

                    REQ: begin
                        // Request and address stay put until memory answers.
                        if (imem_ack) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            pc          <= pc_inc;
                            imem_req    <= 1'b0;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end

                    HOLD: begin
                        // Word is presented to decode until it is accepted;
                        // a pending halt is honoured only once it is drained.
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                            if (halt_pend) begin
                                halted <= 1'b1;
                                state  <= HALT;
                            end else begin
                                imem_req <= 1'b1;
                                state    <= REQ;
                            end
                        end
                    end

                    HALT: begin
                        // Sticky until reset; redirect and halt have no effect.
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b0;
                        halted      <= 1'b1;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        halt;
    logic        halted;
    logic [7:0]  pc;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .halted      (halted),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One stimulus record: inputs for one cycle and outputs expected after
    // the following rising edge.
    typedef struct {
        logic        rst;
        logic        ack;
        logic [15:0] rdata;
        logic        ready;
        logic        redirect;
        logic [7:0]  rpc;
        logic        halt;
        logic        e_req;
        logic        e_valid;
        logic        e_halted;
        logic [7:0]  e_pc;
        logic [15:0] e_instr;
        logic [7:0]  e_ipc;
    } vec_t;

    // Behavioural view of the sequencer: what the core is doing, expressed
    // as "started / fetching / presenting / stopped" facts.
    typedef struct {
        logic        started;
        logic        fetching;
        logic        presenting;
        logic        stopped;
        logic        halt_asked;
        logic [7:0]  pc;
        logic [15:0] word;
        logic [7:0]  word_pc;
    } model_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic a, input logic [15:0] d,
                                input logic rdy, input logic rd, input logic [7:0] rp,
                                input logic h, input logic eq, input logic ev,
                                input logic eh, input logic [7:0] ep,
                                input logic [15:0] ei, input logic [7:0] eip);
        vec_t v;
        v.rst = r; v.ack = a; v.rdata = d; v.ready = rdy; v.redirect = rd;
        v.rpc = rp; v.halt = h; v.e_req = eq; v.e_valid = ev; v.e_halted = eh;
        v.e_pc = ep; v.e_instr = ei; v.e_ipc = eip;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs away from the active edge, then let it clock.
    task automatic step(input logic r, input logic a, input logic [15:0] d,
                        input logic rdy, input logic rd, input logic [7:0] rp,
                        input logic h);
        @(negedge clk);
        rst = r; imem_ack = a; imem_rdata = d; instr_ready = rdy;
        redirect = rd; redirect_pc = rp; halt = h;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic e_req, input logic e_valid,
                               input logic e_halted, input logic [7:0] e_pc,
                               input logic [15:0] e_instr, input logic [7:0] e_ipc);
        check({tag, ".imem_req"},    32'(imem_req),    32'(e_req));
        check({tag, ".instr_valid"}, 32'(instr_valid), 32'(e_valid));
        check({tag, ".halted"},      32'(halted),      32'(e_halted));
        check({tag, ".pc"},          32'(pc),          32'(e_pc));
        check({tag, ".instr"},       32'(instr),       32'(e_instr));
        check({tag, ".instr_pc"},    32'(instr_pc),    32'(e_ipc));
        if (e_req) check({tag, ".imem_addr"}, 32'(imem_addr), 32'(e_pc));
    endtask

    // Next behaviour of the sequencer given this cycle's inputs.
    function automatic model_t model_next(input model_t m, input logic r, input logic a,
                                          input logic [15:0] d, input logic rdy,
                                          input logic rd, input logic [7:0] rp,
                                          input logic h);
        model_t n = m;
        if (!r) begin
            n = '{started: 1'b0, fetching: 1'b0, presenting: 1'b0, stopped: 1'b0,
                  halt_asked: 1'b0, pc: 8'h00, word: 16'h0, word_pc: 8'h00};
            return n;
        end
        n.halt_asked = m.halt_asked | h;
        if (m.stopped) return n;
        if (rd) begin
            n.started    = 1'b1;
            n.pc         = rp;
            n.presenting = 1'b0;
            n.fetching   = 1'b1;
        end else if (!m.started) begin
            n.started  = 1'b1;
            n.stopped  = m.halt_asked;
            n.fetching = !m.halt_asked;
        end else if (m.fetching) begin
            if (a) begin
                n.word       = d;
                n.word_pc    = m.pc;
                n.pc         = (m.pc == 8'hFF) ? 8'h00 : m.pc + 8'd1;
                n.fetching   = 1'b0;
                n.presenting = 1'b1;
            end
        end else if (m.presenting && rdy) begin
            n.presenting = 1'b0;
            n.stopped    = m.halt_asked;
            n.fetching   = !m.halt_asked;
        end
        return n;
    endfunction

    // Safety net: the bench must always end by itself.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_t m;
        logic   r, a, rdy, rd, h;
        logic [15:0] d;
        logic [7:0]  rp;

        rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0;

        // rst  ack rdata     rdy rd rpc    h  | req val hlt pc     instr     ipc
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 8'h00));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 16'h0000, 8'h00));
        // Free-run from reset, ack on every request, ready always.
        vecs.push_back(mk(1, 1, 16'h0000, 1, 0, 8'h00, 0, 1, 0, 0, 8'h00, 16'h0000, 8'h00));
        vecs.push_back(mk(1, 1, 16'hA100, 1, 0, 8'h00, 0, 0, 1, 0, 8'h01, 16'hA100, 8'h00));
        vecs.push_back(mk(1, 1, 16'h0000, 1, 0, 8'h00, 0, 1, 0, 0, 8'h01, 16'hA100, 8'h00));
        vecs.push_back(mk(1, 1, 16'hA101, 1, 0, 8'h00, 0, 0, 1, 0, 8'h02, 16'hA101, 8'h01));
        vecs.push_back(mk(1, 1, 16'h0000, 1, 0, 8'h00, 0, 1, 0, 0, 8'h02, 16'hA101, 8'h01));
        vecs.push_back(mk(1, 1, 16'hA102, 1, 0, 8'h00, 0, 0, 1, 0, 8'h03, 16'hA102, 8'h02));
        // Redirect to FE while holding, then wrap FE, FF, 00.
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 8'hFE, 0, 1, 0, 0, 8'hFE, 16'hA102, 8'h02));
        vecs.push_back(mk(1, 1, 16'hB0FE, 1, 0, 8'h00, 0, 0, 1, 0, 8'hFF, 16'hB0FE, 8'hFE));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00, 0, 1, 0, 0, 8'hFF, 16'hB0FE, 8'hFE));
        vecs.push_back(mk(1, 1, 16'hB0FF, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 16'hB0FF, 8'hFF));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00, 0, 1, 0, 0, 8'h00, 16'hB0FF, 8'hFF));
        vecs.push_back(mk(1, 1, 16'hB000, 1, 0, 8'h00, 0, 0, 1, 0, 8'h01, 16'hB000, 8'h00));
        // Decode stalls three cycles; stray acks while idle are ignored.
        vecs.push_back(mk(1, 1, 16'hEEEE, 0, 0, 8'h00, 0, 0, 1, 0, 8'h01, 16'hB000, 8'h00));
        vecs.push_back(mk(1, 1, 16'hEEEE, 0, 0, 8'h00, 0, 0, 1, 0, 8'h01, 16'hB000, 8'h00));
        vecs.push_back(mk(1, 1, 16'hEEEE, 0, 0, 8'h00, 0, 0, 1, 0, 8'h01, 16'hB000, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00, 0, 1, 0, 0, 8'h01, 16'hB000, 8'h00));
        // Redirect to 40 collides with an ack: data dropped, no increment.
        vecs.push_back(mk(1, 1, 16'hDEAD, 0, 1, 8'h40, 0, 1, 0, 0, 8'h40, 16'hB000, 8'h00));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00, 0, 1, 0, 0, 8'h40, 16'hB000, 8'h00));
        vecs.push_back(mk(1, 1, 16'hC040, 0, 0, 8'h00, 0, 0, 1, 0, 8'h41, 16'hC040, 8'h40));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00, 0, 1, 0, 0, 8'h41, 16'hC040, 8'h40));
        // Halt pulse during REQ, ack two cycles later: word still delivered.
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00, 1, 1, 0, 0, 8'h41, 16'hC040, 8'h40));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00, 0, 1, 0, 0, 8'h41, 16'hC040, 8'h40));
        vecs.push_back(mk(1, 1, 16'h5541, 0, 0, 8'h00, 0, 0, 1, 0, 8'h42, 16'h5541, 8'h41));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00, 0, 0, 1, 0, 8'h42, 16'h5541, 8'h41));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00, 0, 0, 0, 1, 8'h42, 16'h5541, 8'h41));
        // Halted: redirect, halt, ack and ready all have no effect.
        vecs.push_back(mk(1, 1, 16'h7777, 1, 1, 8'h77, 1, 0, 0, 1, 8'h42, 16'h5541, 8'h41));
        vecs.push_back(mk(1, 1, 16'h7777, 1, 0, 8'h00, 0, 0, 0, 1, 8'h42, 16'h5541, 8'h41));
        vecs.push_back(mk(1, 1, 16'h7777, 1, 1, 8'h10, 0, 0, 0, 1, 8'h42, 16'h5541, 8'h41));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ack, vecs[i].rdata, vecs[i].ready,
                 vecs[i].redirect, vecs[i].rpc, vecs[i].halt);
            expect_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_valid,
                        vecs[i].e_halted, vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_ipc);
        end

        // Reset while a word is being presented to decode.
        step(0, 0, 16'h0000, 0, 0, 8'h00, 0);
        expect_outs("rst6.a", 0, 0, 0, 8'h00, 16'h0000, 8'h00);
        step(1, 0, 16'h0000, 0, 0, 8'h00, 0);
        expect_outs("rst6.b", 1, 0, 0, 8'h00, 16'h0000, 8'h00);
        step(1, 1, 16'h6600, 0, 0, 8'h00, 0);
        expect_outs("rst6.c", 0, 1, 0, 8'h01, 16'h6600, 8'h00);
        step(0, 1, 16'h1234, 0, 0, 8'h00, 0);
        expect_outs("rst6.d", 0, 0, 0, 8'h00, 16'h0000, 8'h00);
        step(1, 0, 16'h0000, 0, 0, 8'h00, 0);
        expect_outs("rst6.e", 1, 0, 0, 8'h00, 16'h0000, 8'h00);

        // Redirect and halt together: one fetch from the target, then HALT.
        step(1, 1, 16'h9999, 0, 1, 8'h10, 1);
        expect_outs("rdh.a", 1, 0, 0, 8'h10, 16'h0000, 8'h00);
        step(1, 1, 16'h7710, 0, 0, 8'h00, 0);
        expect_outs("rdh.b", 0, 1, 0, 8'h11, 16'h7710, 8'h10);
        step(1, 0, 16'h0000, 1, 0, 8'h00, 0);
        expect_outs("rdh.c", 0, 0, 1, 8'h11, 16'h7710, 8'h10);

        // Randomized traffic against the behavioural model.
        m = '{default: '0};
        for (int i = 0; i < 3000; i++) begin
            r   = !((i == 0) || ($urandom_range(0, 59) == 0) ||
                    (m.stopped && $urandom_range(0, 7) == 0));
            a   = ($urandom_range(0, 1) == 1);
            d   = 16'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 9) == 0);
            rp  = ($urandom_range(0, 3) == 0) ? (8'hFC | 8'($urandom_range(0, 3)))
                                              : 8'($urandom);
            h   = ($urandom_range(0, 39) == 0);
            m = model_next(m, r, a, d, rdy, rd, rp, h);
            step(r, a, d, rdy, rd, rp, h);
            expect_outs($sformatf("rnd%0d", i), m.fetching, m.presenting, m.stopped,
                        m.pc, m.word, m.word_pc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
